// File: rtl/lpc_frame_arbiter_pkg.sv
// lpc_pkg: shared definitions for the LPC frame arbiter slice.
//   LPC_FRAME_W - width of one LPC frame as consumed by lpc_decoder
//   arb_state_t - arbiter FSM states
//   clog2       - ceiling log2, never less than 1 so single-bit indices stay legal
package lpc_pkg;

  localparam int unsigned LPC_FRAME_W = 80;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) begin
      width++;
    end
    return width;
  endfunction

endpackage

// File: rtl/lpc_frame_arbiter_skid.sv
// axis_skid_buffer: two-entry AXI-Stream skid buffer with registered outputs.
//   clk, rst_n          - clock, asynchronous active-low reset (contents discarded)
//   s_tdata/s_tuser     - upstream payload
//   s_tvalid/s_tready   - upstream handshake; s_tready depends only on occupancy
//   m_tdata/m_tuser     - downstream payload, driven straight from the head register
//   m_tvalid/m_tready   - downstream handshake
// A beat accepted upstream is visible downstream on the next cycle. With
// m_tready held high the buffer sustains one beat per cycle at occupancy 1.
module axis_skid_buffer #(
  parameter int unsigned DATA_W = 80,
  parameter int unsigned USER_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  input  logic              m_tready
);

  logic [DATA_W-1:0] head_data;
  logic [USER_W-1:0] head_user;
  logic [DATA_W-1:0] tail_data;
  logic [USER_W-1:0] tail_user;
  logic [1:0]        count;
  logic              push;
  logic              pop;

  // Ready is a function of registered occupancy only, so m_tready never
  // reaches s_tready combinationally.
  assign s_tready = (count != 2'd2);
  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = head_data;
  assign m_tuser  = head_user;
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data <= '0;
      head_user <= '0;
      tail_data <= '0;
      tail_user <= '0;
      count     <= 2'd0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_data <= s_tdata;
            head_user <= s_tuser;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data <= s_tdata;
            head_user <= s_tuser;
          end else if (push) begin
            tail_data <= s_tdata;
            tail_user <= s_tuser;
            count     <= 2'd2;
          end else if (pop) begin
            count <= 2'd0;
          end
        end
        default: begin
          // Full: no push possible, a pop promotes the tail entry.
          if (pop) begin
            head_data <= tail_data;
            head_user <= tail_user;
            count     <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/lpc_frame_arbiter.sv
// lpc_frame_arbiter: packet-granular round-robin arbiter sharing one
// lpc_decoder among N_CH AXI-Stream sources of LPC frames.
//   ACLK, ARESET_N        - clock, asynchronous active-low reset
//   S_TDATA               - channel frames, channel i at [i*DATA_W +: DATA_W]
//   S_TVALID/S_TLAST      - per-channel valid / end of packet
//   S_TREADY              - per-channel ready (only the granted channel, only in XFER)
//   CH_EN                 - arbitration enable mask, sampled only when choosing a grant
//   M_TDATA/M_TVALID/M_TREADY/M_TLAST - stream to the decoder
//   M_TUSER               - high on the first beat of each packet
//   M_TID                 - source channel of the current beat
//   GRANT_ACTIVE          - high while a packet grant is held
//   STALL_ERR             - one-cycle pulse when the granted source idles STALL_LIMIT cycles
module lpc_frame_arbiter
  import lpc_pkg::*;
#(
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned DATA_W      = LPC_FRAME_W,
  parameter  int unsigned STALL_LIMIT = 256,
  localparam int unsigned CH_W        = clog2(N_CH)
) (
  input  logic                     ACLK,
  input  logic                     ARESET_N,
  input  logic [N_CH*DATA_W-1:0]   S_TDATA,
  input  logic [N_CH-1:0]          S_TVALID,
  input  logic [N_CH-1:0]          S_TLAST,
  output logic [N_CH-1:0]          S_TREADY,
  input  logic [N_CH-1:0]          CH_EN,
  output logic [DATA_W-1:0]        M_TDATA,
  output logic                     M_TVALID,
  input  logic                     M_TREADY,
  output logic                     M_TLAST,
  output logic                     M_TUSER,
  output logic [CH_W-1:0]          M_TID,
  output logic                     GRANT_ACTIVE,
  output logic                     STALL_ERR
);

  localparam int unsigned CNT_W  = clog2(STALL_LIMIT + 1);
  localparam int unsigned USER_W = CH_W + 2;

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   grant_nxt;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   rr_ptr_nxt;
  logic              first_beat;
  logic              first_beat_nxt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  stall_cnt_nxt;

  logic [N_CH-1:0]   req;
  logic              src_valid;
  logic              src_last;
  logic [DATA_W-1:0] src_data;
  logic              beat_valid;
  logic              beat_accept;
  logic              skid_ready;
  logic [USER_W-1:0] skid_in_user;
  logic [USER_W-1:0] skid_out_user;

  // First requesting channel after ptr, wrapping modulo N_CH; ptr itself is
  // checked last so the previous winner has lowest priority.
  function automatic logic [CH_W-1:0] rr_pick(input logic [N_CH-1:0] r,
                                              input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0] pick;
    logic            found;
    int unsigned     idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N_CH; off++) begin
      idx = (32'(ptr) + off) % N_CH;
      if (!found && r[CH_W'(idx)]) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge ACLK or negedge ARESET_N) begin
    if (!ARESET_N) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= CH_W'(N_CH - 1);
      first_beat <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      rr_ptr     <= rr_ptr_nxt;
      first_beat <= first_beat_nxt;
      stall_cnt  <= stall_cnt_nxt;
    end
  end

  always_comb begin
    req         = S_TVALID & CH_EN;
    src_valid   = S_TVALID[grant];
    src_last    = S_TLAST[grant];
    src_data    = S_TDATA[32'(grant) * DATA_W +: DATA_W];
    beat_valid  = (state == XFER) && src_valid;
    beat_accept = beat_valid && skid_ready;

    S_TREADY = '0;
    if (state == XFER) begin
      S_TREADY[grant] = skid_ready;
    end

    state_nxt      = state;
    grant_nxt      = grant;
    rr_ptr_nxt     = rr_ptr;
    first_beat_nxt = first_beat;
    stall_cnt_nxt  = stall_cnt;
    STALL_ERR      = 1'b0;

    case (state)
      IDLE: begin
        if (req != '0) begin
          grant_nxt      = rr_pick(req, rr_ptr);
          first_beat_nxt = 1'b1;
          stall_cnt_nxt  = '0;
          state_nxt      = XFER;
        end
      end
      XFER: begin
        if (beat_accept) begin
          first_beat_nxt = 1'b0;
          stall_cnt_nxt  = '0;
          if (src_last) begin
            rr_ptr_nxt = grant;
            state_nxt  = IDLE;
          end
        end else if (!src_valid && skid_ready &&
                     (stall_cnt < CNT_W'(STALL_LIMIT))) begin
          // Saturates at the limit so the error fires once per stall.
          stall_cnt_nxt = stall_cnt + CNT_W'(1);
          if (stall_cnt == CNT_W'(STALL_LIMIT - 1)) begin
            STALL_ERR = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign skid_in_user = {grant, first_beat, src_last};
  assign GRANT_ACTIVE = (state == XFER);

  axis_skid_buffer #(
    .DATA_W (DATA_W),
    .USER_W (USER_W)
  ) u_skid (
    .clk      (ACLK),
    .rst_n    (ARESET_N),
    .s_tdata  (src_data),
    .s_tuser  (skid_in_user),
    .s_tvalid (beat_valid),
    .s_tready (skid_ready),
    .m_tdata  (M_TDATA),
    .m_tuser  (skid_out_user),
    .m_tvalid (M_TVALID),
    .m_tready (M_TREADY)
  );

  assign M_TID   = skid_out_user[USER_W-1:2];
  assign M_TUSER = skid_out_user[1];
  assign M_TLAST = skid_out_user[0];

endmodule

// File: tb/tb_lpc_frame_arbiter.sv
// Scoreboard bench for lpc_frame_arbiter: per-channel source models feed
// directed packets, expected M-side beats are queued in service order, and a
// negedge monitor pops and compares every M-side handshake.
module tb_lpc_frame_arbiter;

  localparam int unsigned N_CH   = 4;
  localparam int unsigned DATA_W = 80;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned LIMIT  = 8;

  logic                   ACLK     = 1'b0;
  logic                   ARESET_N = 1'b0;
  logic [N_CH*DATA_W-1:0] S_TDATA  = '0;
  logic [N_CH-1:0]        S_TVALID = '0;
  logic [N_CH-1:0]        S_TLAST  = '0;
  logic [N_CH-1:0]        S_TREADY;
  logic [N_CH-1:0]        CH_EN    = '1;
  logic [DATA_W-1:0]      M_TDATA;
  logic                   M_TVALID;
  logic                   M_TREADY = 1'b1;
  logic                   M_TLAST;
  logic                   M_TUSER;
  logic [CH_W-1:0]        M_TID;
  logic                   GRANT_ACTIVE;
  logic                   STALL_ERR;

  lpc_frame_arbiter #(
    .N_CH        (N_CH),
    .DATA_W      (DATA_W),
    .STALL_LIMIT (LIMIT)
  ) dut (
    .ACLK         (ACLK),
    .ARESET_N     (ARESET_N),
    .S_TDATA      (S_TDATA),
    .S_TVALID     (S_TVALID),
    .S_TLAST      (S_TLAST),
    .S_TREADY     (S_TREADY),
    .CH_EN        (CH_EN),
    .M_TDATA      (M_TDATA),
    .M_TVALID     (M_TVALID),
    .M_TREADY     (M_TREADY),
    .M_TLAST      (M_TLAST),
    .M_TUSER      (M_TUSER),
    .M_TID        (M_TID),
    .GRANT_ACTIVE (GRANT_ACTIVE),
    .STALL_ERR    (STALL_ERR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    int unsigned       gap;
  } src_beat_t;

  typedef struct {
    logic [CH_W-1:0]   tid;
    logic              user;
    logic              last;
    logic [DATA_W-1:0] data;
  } exp_beat_t;

  src_beat_t   srcq [N_CH][$];
  exp_beat_t   sb [$];
  int unsigned gapcnt [N_CH] = '{default: 0};
  logic [N_CH-1:0] hs = '0;

  int          total = 0;
  int          bad   = 0;
  int unsigned seen  = 0;
  int unsigned pulses = 0;
  logic        trk = 1'b0;
  int unsigned idle_n = 0;
  int unsigned pulse_at = 0;
  logic        pulse_ga = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [127:0] pk(input logic [CH_W-1:0] tid, input logic user,
                                      input logic last, input logic [DATA_W-1:0] data);
    logic [127:0] v;
    v = '0;
    v[DATA_W+CH_W+1:0] = {tid, user, last, data};
    return v;
  endfunction

  task automatic src_pkt(input int ch, input int unsigned n, input logic [DATA_W-1:0] base,
                         input int unsigned gidx, input int unsigned glen);
    src_beat_t b;
    for (int unsigned k = 0; k < n; k++) begin
      b.data = base + DATA_W'(k);
      b.last = (k == n - 1);
      b.gap  = (k == gidx) ? glen : 0;
      srcq[ch].push_back(b);
    end
  endtask

  task automatic exp_pkt(input int ch, input int unsigned n, input logic [DATA_W-1:0] base);
    exp_beat_t e;
    for (int unsigned k = 0; k < n; k++) begin
      e.tid  = CH_W'(ch);
      e.user = (k == 0);
      e.last = (k == n - 1);
      e.data = base + DATA_W'(k);
      sb.push_back(e);
    end
  endtask

  task automatic send(input int ch, input int unsigned n, input logic [DATA_W-1:0] base);
    src_pkt(ch, n, base, n, 0);
    exp_pkt(ch, n, base);
  endtask

  task automatic drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    repeat (3) @(negedge ACLK);
    check(name, 128'(sb.size()), 0);
  endtask

  task automatic wait_seen(input int unsigned target, input string name);
    int unsigned n = 0;
    while (seen < target && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    check(name, 128'(seen >= target), 1);
  endtask

  // Source models: present the head beat after its gap, pop on handshake.
  always @(posedge ACLK) begin
    #1;
    for (int i = 0; i < N_CH; i++) begin
      if (!ARESET_N) gapcnt[i] = 0;
      if (hs[i] && srcq[i].size() > 0) begin
        srcq[i].delete(0);
        gapcnt[i] = 0;
      end
      S_TVALID[i] = 1'b0;
      S_TLAST[i]  = 1'b0;
      if (srcq[i].size() > 0) begin
        if (gapcnt[i] < srcq[i][0].gap) begin
          gapcnt[i]++;
        end else begin
          S_TVALID[i] = 1'b1;
          S_TLAST[i]  = srcq[i][0].last;
          S_TDATA[i*DATA_W +: DATA_W] = srcq[i][0].data;
        end
      end
    end
  end

  // Monitor: sample between edges; a handshake seen here completes at the next posedge.
  logic         pv = 1'b0;
  logic         pr = 1'b0;
  logic [127:0] pbeat = '0;
  always @(negedge ACLK) begin
    logic [127:0] cur;
    exp_beat_t    e;
    cur = pk(M_TID, M_TUSER, M_TLAST, M_TDATA);
    hs  = S_TVALID & S_TREADY & {N_CH{ARESET_N}};
    if (ARESET_N && pv && !pr) begin
      check("m_hold_valid", 128'(M_TVALID), 1);
      check("m_hold_payload", cur, pbeat);
    end
    if (ARESET_N && M_TVALID && M_TREADY) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL m_unexpected_beat: got=%0h want=none", cur);
      end else begin
        e = sb.pop_front();
        check("m_beat", cur, pk(e.tid, e.user, e.last, e.data));
      end
      seen++;
    end
    if (trk && GRANT_ACTIVE && !S_TVALID[0]) idle_n++;
    if (STALL_ERR) begin
      pulses++;
      pulse_at = idle_n;
      pulse_ga = GRANT_ACTIVE;
    end
    pv    = ARESET_N && M_TVALID;
    pr    = M_TREADY;
    pbeat = cur;
  end

  task automatic do_reset();
    ARESET_N = 1'b0;
    sb.delete();
    for (int i = 0; i < N_CH; i++) srcq[i].delete();
    repeat (2) @(posedge ACLK);
    #3 ARESET_N = 1'b1;
  endtask

  initial begin
    int unsigned s0;
    int unsigned p0;

    // Reset state
    repeat (3) @(posedge ACLK);
    #2;
    check("rst_m_tvalid", 128'(M_TVALID), 0);
    check("rst_s_tready", 128'(S_TREADY), 0);
    check("rst_grant", 128'(GRANT_ACTIVE), 0);
    check("rst_stall", 128'(STALL_ERR), 0);
    check("rst_m_payload", pk(M_TID, M_TUSER, M_TLAST, M_TDATA), 0);
    ARESET_N = 1'b1;

    // 1: basic 3-beat packet on ch2, latency and first-beat tagging
    @(negedge ACLK);
    send(2, 3, 80'hA);
    @(negedge ACLK);
    check("t1_grant_t", 128'(GRANT_ACTIVE), 0);
    check("t1_src_valid", 128'(S_TVALID[2]), 1);
    @(negedge ACLK);
    check("t1_grant_t1", 128'(GRANT_ACTIVE), 1);
    check("t1_m_empty_t1", 128'(M_TVALID), 0);
    @(negedge ACLK);
    check("t1_v0", 128'(M_TVALID), 1);
    check("t1_beat0", pk(M_TID, M_TUSER, M_TLAST, M_TDATA), pk(2'd2, 1'b1, 1'b0, 80'hA));
    @(negedge ACLK);
    check("t1_v1", 128'(M_TVALID), 1);
    check("t1_beat1", pk(M_TID, M_TUSER, M_TLAST, M_TDATA), pk(2'd2, 1'b0, 1'b0, 80'hB));
    @(negedge ACLK);
    check("t1_v2", 128'(M_TVALID), 1);
    check("t1_beat2", pk(M_TID, M_TUSER, M_TLAST, M_TDATA), pk(2'd2, 1'b0, 1'b1, 80'hC));
    drain("t1_drain");

    // 2: round robin from reset: ch0, ch1, ch3, then ch0's queued second packet
    do_reset();
    @(negedge ACLK);
    send(0, 2, 80'hC0DE_0000_0000_0000_0010);
    send(1, 2, 80'hC0DE_0000_0000_0000_0020);
    send(3, 2, 80'hC0DE_0000_0000_0000_0030);
    send(0, 2, 80'hBEEF_0000_0000_0000_0040);
    drain("t2_drain");

    // 3: backpressure mid 6-beat packet
    s0 = seen;
    @(negedge ACLK);
    send(1, 6, 80'h1234_5678_9ABC_DEF0_0100);
    wait_seen(s0 + 2, "t3_reach_beat2");
    @(posedge ACLK);
    #1 M_TREADY = 1'b0;
    s0 = seen;
    repeat (5) @(negedge ACLK);
    check("t3_sready_low", 128'(S_TREADY[1]), 0);
    check("t3_m_valid_held", 128'(M_TVALID), 1);
    check("t3_no_pop_stalled", 128'(seen), 128'(s0));
    @(posedge ACLK);
    #1 M_TREADY = 1'b1;
    drain("t3_drain");

    // 4: masked ch1 is never granted; unmasked then cleared mid-packet completes
    @(negedge ACLK);
    CH_EN = 4'b1101;
    src_pkt(1, 3, 80'h50, 1, 3);
    send(3, 2, 80'h60);
    drain("t4_drain_ch3");
    s0 = seen;
    repeat (20) @(negedge ACLK);
    check("t4_masked_idle", 128'(GRANT_ACTIVE), 0);
    check("t4_masked_no_beat", 128'(seen), 128'(s0));
    exp_pkt(1, 3, 80'h50);
    CH_EN = 4'b1111;
    wait_seen(s0 + 1, "t4_ch1_started");
    CH_EN = 4'b1101;
    drain("t4_drain_ch1");
    CH_EN = 4'b1111;

    // 5: ch0 idles 12 cycles after beat 1 with a limit of 8
    p0 = pulses;
    idle_n = 0;
    trk = 1'b1;
    @(negedge ACLK);
    src_pkt(0, 3, 80'h70, 1, 12);
    exp_pkt(0, 3, 80'h70);
    drain("t5_drain");
    trk = 1'b0;
    check("t5_one_pulse", 128'(pulses - p0), 1);
    check("t5_pulse_idle_cycle", 128'(pulse_at), 8);
    check("t5_grant_at_pulse", 128'(pulse_ga), 1);
    check("t5_grant_held_idle", 128'(idle_n), 12);

    // 6: reset during a packet, then ch0 wins first with a single-beat packet
    s0 = seen;
    @(negedge ACLK);
    send(1, 5, 80'h80);
    wait_seen(s0 + 1, "t6_reach_beat");
    @(posedge ACLK);
    #2;
    ARESET_N = 1'b0;
    sb.delete();
    for (int i = 0; i < N_CH; i++) srcq[i].delete();
    #1;
    check("t6_async_m_tvalid", 128'(M_TVALID), 0);
    check("t6_async_grant", 128'(GRANT_ACTIVE), 0);
    check("t6_async_s_tready", 128'(S_TREADY), 0);
    check("t6_async_payload", pk(M_TID, M_TUSER, M_TLAST, M_TDATA), 0);
    repeat (2) @(posedge ACLK);
    #3 ARESET_N = 1'b1;
    @(negedge ACLK);
    src_pkt(2, 2, 80'hA0, 2, 0);
    src_pkt(0, 1, 80'h90, 1, 0);
    exp_pkt(0, 1, 80'h90);
    exp_pkt(2, 2, 80'hA0);
    drain("t6_drain");

    check("stall_pulses_total", 128'(pulses), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lpc_frame_arbiter.md
Name: lpc_frame_arbiter

Overview:
- Shares one lpc_decoder among N_CH independent AXI-Stream sources of 80-bit LPC frames.
- Arbitration is round-robin at packet granularity. A grant is held from the first beat until the TLAST beat, so per-channel decoder filter state is never interleaved.
- Sits directly in front of lpc_decoder: M_* drives TDATA/TVALID/TLAST/TUSER, and M_TID is carried alongside for routing OUT_DECODED.

Parameters:
- N_CH, 4: number of requesting channels (2..16).
- DATA_W, 80: frame width; must match the lpc_decoder TDATA width.
- STALL_LIMIT, 256: consecutive source-idle cycles mid-packet before STALL_ERR is raised.
- CH_W, clog2(N_CH): localparam, width of channel index.

Ports:
- ACLK  in  1  clock.
- ARESET_N  in  1  asynchronous active-low reset.
- S_TDATA  in  N_CH*DATA_W  channel frames; channel i occupies bits [i*DATA_W +: DATA_W].
- S_TVALID  in  N_CH  per-channel valid.
- S_TLAST  in  N_CH  per-channel end of packet.
- S_TREADY  out  N_CH  per-channel ready.
- CH_EN  in  N_CH  arbitration enable mask.
- M_TDATA  out  DATA_W  frame to decoder.
- M_TVALID  out  1  valid to decoder.
- M_TREADY  in  1  decoder ready.
- M_TLAST  out  1  end of packet.
- M_TUSER  out  1  high on the first beat of each packet (decoder state restart).
- M_TID  out  CH_W  source channel of the current beat.
- GRANT_ACTIVE  out  1  high while the FSM is in XFER.
- STALL_ERR  out  1  one-cycle pulse on a source stall.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; rr_ptr=N_CH-1 (so channel 0 wins first); skid buffer empty; stall counter 0. Reset is asynchronous, and in-flight beats are discarded.
- FSM IDLE:
  - req = S_TVALID & CH_EN.
  - If req≠0: grant = first set bit scanning rr_ptr+1, rr_ptr+2, … modulo N_CH. Register grant; next state XFER.
  - If req=0: stay in IDLE.
  - S_TREADY = 0 in IDLE.
- FSM XFER:
  - S_TREADY[grant] = skid_in_ready; all other bits 0.
  - Beat accepted when S_TVALID[grant] & S_TREADY[grant].
  - Accepted beat with S_TLAST[grant]=1: rr_ptr←grant; next state IDLE.
  - CH_EN changes and other channels' valids are ignored until packet end; no mid-packet abort.
- M_TUSER tagging: a first_beat flag is set on IDLE→XFER and cleared on the first accepted beat. It travels with the beat as TUSER; TID = grant travels with every beat.
- Skid buffer:
  - 2 entries, registered outputs.
  - An accepted beat appears on M_* the next cycle.
  - Full throughput of 1 beat/cycle when M_TREADY=1.
  - skid_in_ready deasserts only when both entries are held. No combinational path from M_TREADY to S_TREADY.
- M-side AXI rule: once M_TVALID=1, M_TDATA/M_TLAST/M_TUSER/M_TID are stable until M_TREADY=1.
- Inter-packet gap: one IDLE cycle on the input side. The skid buffer may hide this on the M side if it is backpressured.
- Stall detection (XFER only):
  - Counter increments on each cycle with S_TVALID[grant]=0, and clears on an accepted beat.
  - Reaching STALL_LIMIT: STALL_ERR=1 for exactly one cycle, then the counter holds until the next accepted beat.
  - The grant is kept.
  - Cycles stalled by M_TREADY=0 (skid full) do not count.
- Single requester: re-granted every packet, with one IDLE cycle between packets.
- Single-beat packet (TLAST on first beat): M_TUSER=1 and M_TLAST=1 on the same beat.

Decomposition:
- Package lpc_pkg: LPC_FRAME_W=80, FSM state encoding (IDLE, XFER), clog2 function.
- Sub-module axis_skid_buffer (params DATA_W, USER_W). Payload = {TID, TUSER, TLAST, TDATA}.
- The round-robin priority scan stays in the arbiter as a function.

Test Plan:
1. Basic packet: N_CH=4; ch2 sends 3-beat packet 0xA,0xB,0xC (TLAST on 0xC); M_TREADY=1. Expect: GRANT_ACTIVE at t+1; M beats 0xA(TUSER=1,TID=2), 0xB, 0xC(TLAST=1) on consecutive cycles starting t+2.
2. Round-robin order: ch0, ch1, ch3 each hold 2-beat packets from reset. Expect service order 0,1,3. A second ch0 packet queued during ch3's service is served after ch3; no channel is served twice while another waits.
3. Backpressure: M_TREADY=0 for 5 cycles mid 6-beat packet. Expect: S_TREADY falls after 2 buffered beats; no beat lost or duplicated; M_* stable while stalled; order preserved.
4. CH_EN mask: CH_EN[1]=0 while ch1 valid → ch1 never granted. CH_EN[1] cleared mid-packet of a granted ch1 → packet completes fully.
5. Source stall: STALL_LIMIT=8; ch0 drops TVALID after beat 1 for 12 cycles. Expect: one STALL_ERR pulse on the 8th idle cycle; grant held; remaining beats complete with TID=0.
6. Reset mid-packet: ARESET_N low during beat 2. Expect: outputs 0 immediately (asynchronous); after release, the next packet is granted to ch0 first and carries TUSER=1.
